random_word_collector: RTL and testbench
========================================

Name: random_word_collector

Overview:
- Consumer end of the single-bit random stream produced by the debiasing blocks: takes a bit-strobe/bit pair and assembles WIDTH-bit random words.
- Presents each word on a valid/ready output with a one-word holding register, so collection continues while the consumer stalls.
- Sits between a debiaser and any word-wide consumer (PRNG seeding, bus register, FIFO).

Parameters:
WIDTH, 8, output word width in bits; legal range 2..32.
RCT_CUTOFF, 32, repetition-count cutoff for the optional health test; legal range 2..255; unused without the macro.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
in_strobe  input  1  bit strobe from the debiaser; one bit is captured per low-to-high transition.
in_bit  input  1  random bit; sampled in the edge-detect cycle.
flush  input  1  discards the partial word; does not affect the holding register.
out_valid  output  1  holding register contains an unread word.
out_ready  input  1  consumer accepts the word when high together with out_valid.
out_word  output  WIDTH  assembled word; first captured bit in the MSB.
overrun  output  1  sticky: a completed word was dropped because the holding register was full.
clear_overrun  input  1  clears overrun.
health_fail  output  1  sticky health-test failure flag; constant 0 without the macro.

Behaviour:
- Reset (rst_n low at posedge):
  - out_valid=0, out_word=0, overrun=0, health_fail=0.
  - Shift register=0, bit counter=0.
  - strobe_q=1, so a strobe held high through reset release is not a capture.
- Capture: capture = in_strobe & ~strobe_q; strobe_q <= in_strobe every cycle.
  - On capture: shift <= {shift[WIDTH-2:0], in_bit}; count increments.
  - A strobe held high for N cycles yields exactly one capture.
- Word completion: a capture with count==WIDTH-1. Count wraps to 0 and the completed word is {shift[WIDTH-2:0], in_bit}.
- Holding register rules, evaluated in priority order at posedge:
  - (a) Completion and (out_valid==0 or out_ready==1): out_word <= completed word, out_valid <= 1. Back-to-back handover has no gap and no overrun.
  - (b) Completion with out_valid==1 and out_ready==0: word dropped, overrun <= 1, out_word unchanged.
  - (c) No completion and out_valid & out_ready: out_valid <= 0; out_word keeps its last value.
- Latency: out_valid rises on the posedge after the capture cycle of the last bit. The word's bits are never mixed with those of the following word.
- flush: count <= 0 and shift <= 0.
  - A capture in the same cycle is discarded; flush wins.
  - out_valid, out_word and overrun are unaffected.
- clear_overrun: overrun <= 0. If a drop occurs in the same cycle, set wins (overrun stays 1).
- Reset mid-word or mid-handshake: everything returns to reset values and the partial word is lost. There is no requirement on the consumer side.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
Macro RANDOM_COLLECT_HEALTH_EN.
- Defined:
  - Repetition-count test on captured bits. A run counter holds the length of the current run of identical bits; it resets to 1 on a changed bit and saturates at RCT_CUTOFF.
  - When the run reaches RCT_CUTOFF, health_fail <= 1 (sticky until rst_n).
  - While health_fail==1, completed words are silently discarded: not loaded, no overrun. A word already in the holding register stays readable.
  - flush does not reset the run counter.
- Undefined: no run counter is built, health_fail is tied to 0, and every completed word follows the holding register rules.

Test Plan:
1. Reset, out_ready=1, capture bits 1,0,1,1,0,0,1,0 (WIDTH=8) -> out_valid=1 exactly one cycle after the 8th capture, out_word=0xB2, then out_valid=0 the next cycle.
2. in_strobe held high 5 cycles, low 1 cycle, high 1 cycle -> exactly 2 captures. A strobe high across rst_n release gives 0 captures until it goes low then high.
3. out_ready=0, stream 0xA5 then 0x3C -> out_valid=1, out_word=0xA5, overrun=1. Pulse clear_overrun -> overrun=0. Pulse clear_overrun in the same cycle as another drop -> overrun stays 1.
4. Holding 0xA5 with out_ready asserted in the completion cycle of 0x3C -> out_word=0x3C next cycle, out_valid stays 1, overrun=0.
5. Capture 3 bits, pulse flush (also once coincident with a capture), then stream 0x5A -> out_word=0x5A. Same result with rst_n pulsed instead of flush.
6. With the macro and RCT_CUTOFF=32, stream 32 zeros then 0x5A -> health_fail=1 one cycle after the 32nd capture; words 0x00 delivered before the failure; 0x5A never presented; overrun=0. Without the macro, the same stimulus -> health_fail=0 and words 0x00,0x00,0x00,0x00,0x5A delivered.

Source files
------------

// File: rtl/random_word_collector_if.sv
// Bundle of the bit-stream input, word output handshake and status flags
// of random_word_collector. The collector uses the slave modport; whatever
// drives the bit stream and consumes the words uses the master modport.
interface random_word_collector_if #(
    parameter int WIDTH = 8
);
    logic             in_strobe;
    logic             in_bit;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic             overrun;
    logic             clear_overrun;
    logic             health_fail;

    modport slave (
        input  in_strobe,
        input  in_bit,
        input  flush,
        input  out_ready,
        input  clear_overrun,
        output out_valid,
        output out_word,
        output overrun,
        output health_fail
    );

    modport master (
        output in_strobe,
        output in_bit,
        output flush,
        output out_ready,
        output clear_overrun,
        input  out_valid,
        input  out_word,
        input  overrun,
        input  health_fail
    );
endinterface

// File: rtl/random_word_collector.sv
// random_word_collector: assembles WIDTH-bit words from a strobed random
// bit stream (first captured bit lands in the MSB) and offers them through
// a one-word holding register.
//
// Output handshake: a word transfers on a posedge where out_valid and
// out_ready are both high. out_valid never depends combinationally on
// out_ready. A word completed while the holding register is full and not
// being read is dropped and flagged on the sticky overrun output.
//
// Optional build macro RANDOM_COLLECT_HEALTH_EN adds a repetition-count
// health test; once it trips, health_fail stays high until reset and newly
// completed words are discarded without raising overrun.
module random_word_collector #(
    parameter int WIDTH      = 8,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    random_word_collector_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    logic             strobe_q;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_word_q;
    logic             overrun_q;

    logic             capture;
    logic             complete;
    logic             deliver;
    logic             health_fail_w;
    logic [WIDTH-1:0] done_word;

    // Rising edge of the strobe is one capture; flush cancels a coincident one.
    assign capture   = bus.in_strobe & ~strobe_q;
    assign complete  = capture & ~bus.flush & (count_q == CW'(WIDTH - 1));
    assign done_word = {shift_q[WIDTH-2:0], bus.in_bit};
    assign deliver   = complete & ~health_fail_w;

    // Next value of the partial-word shifter and its bit counter.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (bus.flush) begin
            shift_d = '0;
            count_d = '0;
        end else if (capture) begin
            shift_d = done_word;
            count_d = complete ? '0 : count_q + CW'(1);
        end
    end

    // Edge detector, shifter, holding register and overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe_q    <= 1'b1;
            shift_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            strobe_q <= bus.in_strobe;
            shift_q  <= shift_d;
            count_q  <= count_d;
            if (deliver && (!out_valid_q || bus.out_ready)) begin
                out_word_q  <= done_word;
                out_valid_q <= 1'b1;
            end else if (deliver) begin
                overrun_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A drop in the same cycle outranks the clear request.
            if (bus.clear_overrun && !(deliver && out_valid_q && !bus.out_ready)) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef RANDOM_COLLECT_HEALTH_EN
    logic [7:0] run_q, run_d;
    logic       last_bit_q;
    logic       health_fail_q;

    // Run length of identical captured bits, saturating at the cutoff.
    always_comb begin
        run_d = run_q;
        if (capture) begin
            if (run_q != 8'd0 && bus.in_bit == last_bit_q) begin
                run_d = (run_q == 8'(RCT_CUTOFF)) ? run_q : run_q + 8'd1;
            end else begin
                run_d = 8'd1;
            end
        end
    end

    // Run tracker and sticky failure flag; flush leaves the run untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q         <= 8'd0;
            last_bit_q    <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            run_q <= run_d;
            if (capture) begin
                last_bit_q <= bus.in_bit;
            end
            if (run_d == 8'(RCT_CUTOFF)) begin
                health_fail_q <= 1'b1;
            end
        end
    end

    assign health_fail_w = health_fail_q;
`else
    logic unused_rct;
    assign unused_rct    = ^8'(RCT_CUTOFF);
    assign health_fail_w = 1'b0;
`endif

    assign bus.out_valid   = out_valid_q;
    assign bus.out_word    = out_word_q;
    assign bus.overrun     = overrun_q;
    assign bus.health_fail = health_fail_w;
endmodule

// File: tb/tb_random_word_collector.sv
// Directed bench for random_word_collector (WIDTH=8, RCT_CUTOFF=32).
// Words expected at the output are queued as they are streamed in and are
// checked in order whenever a handshake completes.
module tb_random_word_collector;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];

    random_word_collector_if #(.WIDTH(8)) bus();

    random_word_collector #(.WIDTH(8), .RCT_CUTOFF(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RANDOM_COLLECT_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: look at the handshake about to happen, then step past the edge.
    task automatic tick();
        logic [7:0] exp_w;
        @(negedge clk);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_word observed=%0h expected=none", bus.out_word);
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("sb_word", {24'd0, bus.out_word}, {24'd0, exp_w});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.in_strobe = 1'b1;
        bus.in_bit    = b;
        tick();
        bus.in_strobe = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        logic [7:0] w;
        rst_n             = 1'b0;
        bus.in_strobe     = 1'b1;
        bus.in_bit        = 1'b1;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b1;
        bus.clear_overrun = 1'b0;
        tick();
        tick();
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_word", {24'd0, bus.out_word}, 0);
        check("rst_overrun", {31'd0, bus.overrun}, 0);
        check("rst_health_fail", {31'd0, bus.health_fail}, 0);

        // Strobe high across reset release must not capture.
        rst_n = 1'b1;
        tick();
        tick();
        bus.in_strobe = 1'b0;
        tick();

        // Basic word 0xB2 with exact latency.
        w = 8'hB2;
        exp_q.push_back(w);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        check("t1_valid_before_last", {31'd0, bus.out_valid}, 0);
        bus.in_strobe = 1'b1;
        bus.in_bit    = w[0];
        tick();
        check("t1_valid_after_last", {31'd0, bus.out_valid}, 1);
        check("t1_word", {24'd0, bus.out_word}, 32'hB2);
        bus.in_strobe = 1'b0;
        tick();
        check("t1_valid_drop", {31'd0, bus.out_valid}, 0);

        // Long strobe gives one capture: 5 high, 1 low, 1 high -> bits 1,0.
        exp_q.push_back(8'hBF);
        bus.in_bit    = 1'b1;
        bus.in_strobe = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.in_strobe = 1'b0;
        tick();
        bus.in_strobe = 1'b1;
        bus.in_bit    = 1'b0;
        tick();
        bus.in_strobe = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        check("t2_word", {24'd0, bus.out_word}, 32'hBF);
        check("t2_queue_drained", exp_q.size(), 0);

        // Stalled consumer: 0xA5 held, 0x3C dropped.
        bus.out_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_word(8'hA5);
        check("t3_valid_held", {31'd0, bus.out_valid}, 1);
        check("t3_overrun_pre", {31'd0, bus.overrun}, 0);
        send_word(8'h3C);
        check("t3_valid", {31'd0, bus.out_valid}, 1);
        check("t3_word_kept", {24'd0, bus.out_word}, 32'hA5);
        check("t3_overrun_set", {31'd0, bus.overrun}, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t3_flush_keeps_overrun", {31'd0, bus.overrun}, 1);
        check("t3_flush_keeps_valid", {31'd0, bus.out_valid}, 1);
        bus.clear_overrun = 1'b1;
        tick();
        bus.clear_overrun = 1'b0;
        check("t3_overrun_cleared", {31'd0, bus.overrun}, 0);
        w = 8'hFF;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        bus.in_strobe     = 1'b1;
        bus.in_bit        = w[0];
        bus.clear_overrun = 1'b1;
        tick();
        bus.clear_overrun = 1'b0;
        bus.in_strobe     = 1'b0;
        check("t3_set_beats_clear", {31'd0, bus.overrun}, 1);
        check("t3_word_still", {24'd0, bus.out_word}, 32'hA5);
        tick();

        // Back-to-back handover while holding 0xA5.
        bus.clear_overrun = 1'b1;
        tick();
        bus.clear_overrun = 1'b0;
        w = 8'h3C;
        exp_q.push_back(w);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        bus.in_strobe = 1'b1;
        bus.in_bit    = w[0];
        bus.out_ready = 1'b1;
        tick();
        bus.in_strobe = 1'b0;
        check("t4_word", {24'd0, bus.out_word}, 32'h3C);
        check("t4_valid", {31'd0, bus.out_valid}, 1);
        check("t4_overrun", {31'd0, bus.overrun}, 0);
        tick();
        check("t4_valid_drop", {31'd0, bus.out_valid}, 0);

        // Flush discards a partial word, including a coincident capture.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        send_bit(1'b0);
        bus.in_strobe = 1'b1;
        bus.in_bit    = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.in_strobe = 1'b0;
        bus.flush     = 1'b0;
        tick();
        exp_q.push_back(8'h5A);
        send_word(8'h5A);
        check("t5_flush_word", {24'd0, bus.out_word}, 32'h5A);

        // Reset mid-word behaves like flush and also clears the holding register.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        tick();
        check("t5_rst_word", {24'd0, bus.out_word}, 0);
        rst_n = 1'b1;
        tick();
        exp_q.push_back(8'h5A);
        send_word(8'h5A);
        check("t5_rst_then_word", {24'd0, bus.out_word}, 32'h5A);

        // Repetition run of 32 zeros, then 0x5A.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 31; i++) send_bit(1'b0);
        check("t6_health_before", {31'd0, bus.health_fail}, 0);
        bus.in_strobe = 1'b1;
        bus.in_bit    = 1'b0;
        tick();
        bus.in_strobe = 1'b0;
        check("t6_health_after", {31'd0, bus.health_fail}, {31'd0, HEALTH});
        check("t6_last_zero_word", {24'd0, bus.out_word}, 0);
        tick();
        if (!HEALTH) exp_q.push_back(8'h5A);
        send_word(8'h5A);
        check("t6_overrun", {31'd0, bus.overrun}, 0);
        check("t6_out_valid", {31'd0, bus.out_valid}, 0);
        check("t6_final_word", {24'd0, bus.out_word}, HEALTH ? 32'h00 : 32'h5A);
        check("t6_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
